// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MIPS mult/multu/div/divu unit owning HI/LO.
// Define MDU_DIV_EN to build the divide path; without it div ops pulse err.
module mdu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        sgn_q, neg_q;
  logic [31:0] a_q, b_q, mcand;
  logic [31:0] a_abs, b_abs;
  logic [64:0] acc, acc_nx;
  logic [32:0] add_a, add_b, sum;
  logic        add_c;
  logic [63:0] prod;
  logic        can_start, accept;
`ifdef MDU_DIV_EN
  logic        div_q, neg_r, b_zero;
  logic [31:0] quo, rem;
`endif

  assign can_start = (state == S_IDLE) ||
                     (state == S_DONE);
`ifdef MDU_DIV_EN
  assign accept = start & can_start;
`else
  assign accept = start & can_start & ~op[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_PREP;
      S_PREP: begin
        busy     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) state_nx = S_FIX;
      end
      S_FIX: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = accept ? S_PREP : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign a_abs = (sgn_q && a_q[31]) ? -a_q : a_q;
  assign b_abs = (sgn_q && b_q[31]) ? -b_q : b_q;

  // One 33-bit adder: add for multiply, subtract for divide.
  always_comb begin
    add_a = acc[64:32];
    add_b = {1'b0, mcand};
    add_c = 1'b0;
`ifdef MDU_DIV_EN
    if (div_q) begin
      add_a = acc[63:31];
      add_b = ~{1'b0, mcand};
      add_c = 1'b1;
    end
`endif
  end

  assign sum = add_a + add_b + {32'd0, add_c};

  always_comb begin
    acc_nx = {1'b0, (acc[0] ? sum : acc[64:32]),
              acc[31:1]};
`ifdef MDU_DIV_EN
    if (div_q)
      acc_nx = sum[32] ? {acc[63:0], 1'b0}
                       : {sum, acc[30:0], 1'b1};
`endif
  end

  assign prod = neg_q ? -acc[63:0] : acc[63:0];
`ifdef MDU_DIV_EN
  assign quo = neg_q ? -acc[31:0] : acc[31:0];
  assign rem = neg_r ? -acc[63:32] : acc[63:32];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= 5'd0;
      sgn_q <= 1'b0;
      neg_q <= 1'b0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      mcand <= 32'd0;
      acc   <= 65'd0;
`ifdef MDU_DIV_EN
      div_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
`endif
    end else begin
      if (accept) begin
        sgn_q <= ~op[0];
        a_q   <= A;
        b_q   <= B;
`ifdef MDU_DIV_EN
        div_q <= op[1];
`endif
      end
      if (state == S_PREP) begin
        cnt   <= 5'd0;
        neg_q <= sgn_q & (a_q[31] ^ b_q[31]);
        mcand <= a_abs;
        acc   <= {33'd0, b_abs};
`ifdef MDU_DIV_EN
        neg_r  <= sgn_q & a_q[31];
        b_zero <= (b_q == 32'd0);
        if (div_q) begin
          mcand <= b_abs;
          acc   <= {33'd0, a_abs};
        end
`endif
      end
      if (state == S_RUN) begin
        cnt <= cnt + 5'd1;
        acc <= acc_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (state == S_FIX) begin
      {HI, LO} <= prod;
`ifdef MDU_DIV_EN
      if (div_q) begin
        HI <= rem;
        LO <= quo;
        // Divide by zero reports the raw dividend.
        if (b_zero) begin
          HI <= a_q;
          LO <= '1;
        end
      end
`endif
    end else if (!busy) begin
      if (hi_we) HI <= wdata;
      if (lo_we) LO <= wdata;
    end
  end

`ifdef MDU_DIV_EN
  assign err = 1'b0;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= start & can_start & op[1];
  end
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: random + directed bench for mdu_sequencer.
// Expectations come from a cycle-age model and plain 64-bit arithmetic.
module tb_mdu_sequencer;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done, err;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  mdu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .err(err),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_res(
    logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (o)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Model: age = edges since acceptance, -1 when idle, 34 = done cycle.
  int          m_age = -1;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;
  bit          m_err = 1'b0;
  bit          m_free;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age = -1; m_hi = 0; m_lo = 0; m_err = 0;
    end else begin
      m_free = (m_age < 0) || (m_age == 34);
      m_err  = 1'b0;
      if (m_free) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
      if (!m_free) begin
        m_age++;
        if (m_age == 34) {m_hi, m_lo} = m_res;
      end else if (start && (DIV_EN || !op[1])) begin
        m_age = 0;
        m_res = ref_res(op, A, B);
      end else begin
        m_age = -1;
        if (start) m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (m_age >= 0) && (m_age <= 33));
    chk("done", done, m_age == 34);
    chk("err", err, m_err);
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    if (err) err_cnt++;
  end

  task automatic run_op(bit now, logic [1:0] o,
                        logic [31:0] a, logic [31:0] b,
                        output int lat, output int bc);
    if (!now) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 60; bc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k - 1;
        break;
      end
      if (busy) bc++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  int lat, bc, dcnt;

  initial begin
    start = 0; op = 0; A = 0; B = 0;
    hi_we = 0; lo_we = 0; wdata = 0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_HI", HI, 0);
    chk("rst_LO", LO, 0);
    #2 reset = 1'b0;

    chk("model_mult", ref_res(2'd0, 32'hFFFF_FFFD, 32'd7),
        64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_div", ref_res(2'd2, 32'h8000_0000,
        32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    run_op(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    chk("multu_lat", lat, 34);
    chk("multu_busy", bc, 34);
    chk("multu_HI", HI, 32'hFFFF_FFFE);
    chk("multu_LO", LO, 32'h0000_0001);
    @(negedge clk);
    chk("done_pulse", done, 0);

    run_op(0, 2'd0, 32'hFFFF_FFFD, 32'd7, lat, bc);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFEB);

`ifdef MDU_DIV_EN
    run_op(0, 2'd2, 32'hFFFF_FFF9, 32'd2, lat, bc);
    chk("div_lat", lat, 34);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);
    run_op(0, 2'd3, 32'd7, 32'd0, lat, bc);
    chk("divz_HI", HI, 32'd7);
    chk("divz_LO", LO, 32'hFFFF_FFFF);
    run_op(0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    chk("ovf_LO", LO, 32'h8000_0000);
    chk("ovf_HI", HI, 32'd0);
`else
    @(posedge clk); #1;
    start = 1; op = 2'd2; A = 32'd7; B = 32'd2;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("rej_err", err, 1);
    chk("rej_busy", busy, 0);
    @(negedge clk);
    chk("rej_err_end", err, 0);
    chk("rej_HI", HI, 32'hFFFF_FFFF);
    chk("rej_LO", LO, 32'hFFFF_FFEB);
`endif

    // mthi and start on the same idle edge
    @(posedge clk); #1;
    start = 1; op = 2'd1; A = 2; B = 3;
    hi_we = 1; wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    start = 0; hi_we = 0;
    @(negedge clk);
    chk("wr_start_HI", HI, 32'hAAAA_5555);
    chk("wr_start_busy", busy, 1);
    dcnt = 0;
    for (int k = 0; k < 50 && !done; k++) @(negedge clk);
    chk("wr_start_res", {HI, LO}, 64'd6);

    // write while busy is dropped; idle write lands
    @(posedge clk); #1;
    start = 1; op = 2'd0; A = 3; B = 5;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1 hi_we = 1; wdata = 32'h1234_5678;
    @(posedge clk); #1 hi_we = 0;
    for (int k = 0; k < 50 && !done; k++) @(negedge clk);
    chk("busy_wr_HI", HI, 32'd0);
    chk("busy_wr_LO", LO, 32'd15);
    @(posedge clk); #1;
    hi_we = 1; wdata = 32'h1234_5678;
    @(posedge clk); #1 hi_we = 0;
    @(negedge clk);
    chk("idle_wr_HI", HI, 32'h1234_5678);

    // second start mid-run is ignored
    @(posedge clk); #1;
    start = 1; op = 2'd1; A = 5; B = 6;
    @(posedge clk); #1 start = 0;
    repeat (10) @(posedge clk);
    #1 start = 1; A = 9; B = 9;
    @(posedge clk); #1 start = 0;
    dcnt = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ign_done_cnt", dcnt, 1);
    chk("ign_res", {HI, LO}, 64'd30);

    // start during DONE
    run_op(0, 2'd1, 32'd11, 32'd13, lat, bc);
    run_op(1, 2'd1, 32'h0001_0000, 32'h0001_0000, lat, bc);
    chk("b2b_lat", lat, 34);
    chk("b2b_res", {HI, LO}, 64'h1_0000_0000);

    // reset during RUN
    @(posedge clk); #1;
    start = 1; op = 2'd1; A = 32'hFFFF; B = 32'hFFFF;
    @(posedge clk); #1 start = 0;
    repeat (16) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_HI", HI, 0);
    chk("mid_rst_LO", LO, 0);
    @(negedge clk);
    #2 reset = 0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("mid_rst_nodone", dcnt, 0);

    repeat (2500) begin
      @(posedge clk); #1;
      start = ($urandom % 4) == 0;
      op    = 2'($urandom);
      A     = pick();
      B     = pick();
      hi_we = ($urandom % 8) == 0;
      lo_we = ($urandom % 8) == 0;
      wdata = $urandom;
    end
    @(posedge clk); #1;
    start = 0; hi_we = 0; lo_we = 0;
    repeat (40) @(negedge clk);

    if (DIV_EN) chk("err_never", err_cnt, 0);
    else chk("err_seen", err_cnt > 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
